// File: rtl/gcd_datapath_if.sv
// gcd_datapath_if: command/flag bundle between the GCD controller (master)
// and the GCD datapath (slave).
//
// Handshake: there is no valid/ready pair. Every strobe (lda, ldb, sel_in,
// sel1, sel2, done) is a level command that is sampled on each rising clock
// edge and acted on in that same cycle. The datapath accepts every command
// unconditionally and never applies back-pressure. The flags (lt/gt/eq) and
// result outputs (gcd_out, gcd_valid, iter_count, err_sel) are registered
// state, or pure functions of registered state. The master may therefore
// sample them on the next edge after it issues a command.
interface gcd_datapath_if #(
  parameter int W  = 16,
  parameter int CW = 8
);
  logic [W-1:0]  data_in;
  logic          lda;
  logic          ldb;
  logic          sel1;
  logic          sel2;
  logic          sel_in;
  logic          done;
  logic          lt;
  logic          gt;
  logic          eq;
  logic [W-1:0]  gcd_out;
  logic          gcd_valid;
  logic [CW-1:0] iter_count;
  logic          err_sel;

  modport master (
    output data_in, lda, ldb, sel1, sel2, sel_in, done,
    input  lt, gt, eq, gcd_out, gcd_valid, iter_count, err_sel
  );

  modport slave (
    input  data_in, lda, ldb, sel1, sel2, sel_in, done,
    output lt, gt, eq, gcd_out, gcd_valid, iter_count, err_sel
  );
endinterface

// File: rtl/gcd_datapath.sv
// gcd_datapath: datapath half of the subtract-based GCD engine.
// The block holds operand registers A and B, a shared subtractor, an input
// mux, result capture, a saturating iteration counter and a sticky
// illegal-select flag.
// Optional feature macro: GCD_DP_ZERO_GUARD_EN. When it is defined, a zero
// operand forces eq and the capture returns the non-zero operand.
module gcd_datapath #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input logic          clk,
  input logic          rst_n,
  gcd_datapath_if.slave dp
);

  localparam logic [CW-1:0] ITER_MAX = '1;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_gcd;
  logic          r_valid;
  logic          r_done_q;
  logic          r_err;
  logic [CW-1:0] r_iter;

  logic [W-1:0]  w_x;
  logic [W-1:0]  w_y;
  logic [W-1:0]  w_diff;
  logic [W-1:0]  w_mux;
  logic [W-1:0]  w_cap;
  logic          w_load;
  logic          w_op_load;
  logic          w_sub_load;
  logic          w_cap_fire;
  logic          w_lt;
  logic          w_gt;
  logic          w_eq;

  // Operand muxes, shared subtractor (modulo 2^W) and input mux
  always_comb begin
    w_x        = dp.sel1 ? r_b : r_a;
    w_y        = dp.sel2 ? r_b : r_a;
    w_diff     = w_x - w_y;
    w_mux      = dp.sel_in ? dp.data_in : w_diff;
    w_load     = dp.lda | dp.ldb;
    w_op_load  = w_load & dp.sel_in;
    w_sub_load = w_load & ~dp.sel_in;
    w_cap_fire = dp.done & ~r_done_q;
  end

  // Comparison flags and capture value, derived only from the A/B registers
  always_comb begin
    w_lt  = (r_a < r_b);
    w_gt  = (r_a > r_b);
    w_eq  = (r_a == r_b);
    w_cap = r_a;
`ifdef GCD_DP_ZERO_GUARD_EN
    // A zero operand ends the loop at once: gcd(0,n)=n, gcd(0,0)=0
    if ((r_a == '0) || (r_b == '0)) begin
      w_lt = 1'b0;
      w_gt = 1'b0;
      w_eq = 1'b1;
    end
    if (r_a == '0) begin
      w_cap = r_b;
    end
`endif
  end

  // Operand register A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
    end else if (dp.lda) begin
      r_a <= w_mux;
    end
  end

  // Operand register B (both strobes load the same mux value)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b <= '0;
    end else if (dp.ldb) begin
      r_b <= w_mux;
    end
  end

  // Iteration counter: cleared by operand loads, saturating on subtract loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter <= '0;
    end else if (w_op_load) begin
      r_iter <= '0;
    end else if (w_sub_load && (r_iter != ITER_MAX)) begin
      r_iter <= r_iter + 1'b1;
    end
  end

  // Edge detector for the done strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= dp.done;
    end
  end

  // Result capture uses the pre-edge A. A same-cycle operand load wins for valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gcd   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_cap_fire) begin
        r_gcd <= w_cap;
      end
      if (w_op_load) begin
        r_valid <= 1'b0;
      end else if (w_cap_fire) begin
        r_valid <= 1'b1;
      end
    end
  end

  // Sticky flag for subtract loads with equal selects (diff forced to 0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_sub_load && (dp.sel1 == dp.sel2)) begin
      r_err <= 1'b1;
    end
  end

  assign dp.lt         = w_lt;
  assign dp.gt         = w_gt;
  assign dp.eq         = w_eq;
  assign dp.gcd_out    = r_gcd;
  assign dp.gcd_valid  = r_valid;
  assign dp.iter_count = r_iter;
  assign dp.err_sel    = r_err;

endmodule
